// File: rtl/multiplier_pipe_array_mult.sv
// Pipelined Baugh-Wooley array multiplier with val/rdy streams on both sides.
// Partial-product rows are spread over NUM_STAGES register stages that share one global enable.

module multiplier_pipe_array_mult_rows #(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 6,
  parameter int ROW_LO  = 0,
  parameter int ROW_HI  = 1,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               mode,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic [P_WIDTH-1:0] acc_in,
  output logic [P_WIDTH-1:0] acc_out
);
  localparam logic [P_WIDTH-1:0] ONE = P_WIDTH'(1);
  // Signed-mode correction constants, applied in the final ripple row.
  localparam logic [P_WIDTH-1:0] BW_CONST =
    (ONE << (X_WIDTH-1)) + (ONE << (Y_WIDTH-1)) + (ONE << (P_WIDTH-1));

  logic [P_WIDTH-1:0] pp;

  always_comb begin
    acc_out = acc_in;
    pp      = '0;
    for (int r = ROW_LO; r < ROW_HI; r++) begin
      if (r < X_WIDTH) begin
        pp = '0;
        // MSB row and MSB column cells are complemented in signed mode; the corner cell is not.
        for (int j = 0; j < Y_WIDTH; j++)
          pp[j] = (x[r % X_WIDTH] & y[j]) ^
                  (mode & ((r == X_WIDTH-1) != (j == Y_WIDTH-1)));
        acc_out = acc_out + (pp << r);
      end else begin
        acc_out = acc_out + (mode ? BW_CONST : '0);
      end
    end
  end
endmodule

module multiplier_pipe_array_mult #(
  parameter  int X_WIDTH    = 4,
  parameter  int Y_WIDTH    = 6,
  parameter  int NUM_STAGES = 2,
  parameter  int P_WIDTH    = X_WIDTH + Y_WIDTH,
  localparam int OCC_W      = (NUM_STAGES == 0) ? 1 : $clog2(NUM_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       istream_val,
  output logic                       istream_rdy,
  input  logic [X_WIDTH+Y_WIDTH:0]   istream_msg,
  output logic                       ostream_val,
  input  logic                       ostream_rdy,
  output logic [P_WIDTH-1:0]         ostream_msg,
  output logic [OCC_W-1:0]           occupancy
);
  localparam int ROWS   = X_WIDTH + 1;
  localparam int NS_DIV = (NUM_STAGES == 0) ? 1 : NUM_STAGES;

  // Last row index (exclusive) folded into stage k; k=-1 yields 0.
  function automatic int row_bound(input int k);
    return ((k + 1) * ROWS + NS_DIV - 1) / NS_DIV;
  endfunction

  typedef struct packed {
    logic               mode;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [P_WIDTH-1:0] acc;
  } stage_t;

  stage_t in_s;
  assign in_s = '{mode: istream_msg[X_WIDTH+Y_WIDTH],
                  x:    istream_msg[X_WIDTH+Y_WIDTH-1:Y_WIDTH],
                  y:    istream_msg[Y_WIDTH-1:0],
                  acc:  '0};

  if (NUM_STAGES == 0) begin : g_comb
    logic [P_WIDTH-1:0] prod;

    multiplier_pipe_array_mult_rows #(
      .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .ROW_LO(0), .ROW_HI(ROWS), .P_WIDTH(P_WIDTH)
    ) u_rows (
      .mode(in_s.mode), .x(in_s.x), .y(in_s.y), .acc_in(in_s.acc), .acc_out(prod)
    );

    assign istream_rdy = ostream_rdy;
    assign ostream_val = istream_val;
    assign ostream_msg = prod;
    assign occupancy   = '0;
  end else begin : g_pipe
    logic [NUM_STAGES-1:0]              vld_pipe;
    logic [NUM_STAGES-1:0][P_WIDTH-1:0] acc_nxt;
    stage_t                             stg_d [NUM_STAGES];
    stage_t                             stg_q [NUM_STAGES];
    logic                               adv;
    logic [OCC_W-1:0]                   cnt;

    // One enable for the whole pipe: bubbles travel with the data instead of collapsing.
    assign adv = ostream_rdy | ~vld_pipe[NUM_STAGES-1];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      stage_t src;
      if (k == 0) begin : g_first
        assign src = in_s;
      end else begin : g_next
        assign src = stg_q[k-1];
      end

      multiplier_pipe_array_mult_rows #(
        .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH),
        .ROW_LO(row_bound(k-1)), .ROW_HI(row_bound(k)), .P_WIDTH(P_WIDTH)
      ) u_rows (
        .mode(src.mode), .x(src.x), .y(src.y), .acc_in(src.acc), .acc_out(acc_nxt[k])
      );

      assign stg_d[k] = '{mode: src.mode, x: src.x, y: src.y, acc: acc_nxt[k]};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_pipe <= '0;
      end else if (adv) begin
        vld_pipe[0] <= istream_val;
        for (int k = 1; k < NUM_STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
    end

    // Datapath is left unreset; the valid bits alone gate what leaves the pipe.
    always_ff @(posedge clk) begin
      if (adv)
        for (int k = 0; k < NUM_STAGES; k++) stg_q[k] <= stg_d[k];
    end

    always_comb begin
      cnt = '0;
      for (int k = 0; k < NUM_STAGES; k++) cnt = cnt + OCC_W'(vld_pipe[k]);
    end

    assign istream_rdy = adv;
    assign ostream_val = vld_pipe[NUM_STAGES-1];
    assign ostream_msg = stg_q[NUM_STAGES-1].acc;
    assign occupancy   = cnt;
  end
endmodule

// File: tb/tb_multiplier_pipe_array_mult.sv
// Self-checking bench: directed vector table and corner sequences on a 2-stage instance,
// plus a random sweep over 0/1/5-stage instances against an integer-arithmetic model.

module tb_multiplier_pipe_array_mult;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // 2-stage instance used for the directed tests
  logic        rst_n, in_val, in_rdy, out_val, out_rdy;
  logic [10:0] in_msg;
  logic [9:0]  out_msg;
  logic [1:0]  occ;

  multiplier_pipe_array_mult #(.X_WIDTH(4), .Y_WIDTH(6), .NUM_STAGES(2)) dut (
    .clk(clk), .reset(rst_n),
    .istream_val(in_val), .istream_rdy(in_rdy), .istream_msg(in_msg),
    .ostream_val(out_val), .ostream_rdy(out_rdy), .ostream_msg(out_msg),
    .occupancy(occ)
  );

  // depth sweep instances sharing one stimulus
  localparam int NSV [3] = '{0, 1, 5};
  logic        s_rst_n, s_val, s_rdy;
  logic [10:0] s_msg;
  logic [2:0]  s_irdy, s_oval;
  logic [9:0]  s_omsg [3];
  logic [31:0] s_occ [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int OW = (NSV[g] == 0) ? 1 : $clog2(NSV[g] + 1);
    logic [OW-1:0] o;
    multiplier_pipe_array_mult #(.X_WIDTH(4), .Y_WIDTH(6), .NUM_STAGES(NSV[g])) u_dut (
      .clk(clk), .reset(s_rst_n),
      .istream_val(s_val), .istream_rdy(s_irdy[g]), .istream_msg(s_msg),
      .ostream_val(s_oval[g]), .ostream_rdy(s_rdy), .ostream_msg(s_omsg[g]),
      .occupancy(o)
    );
    assign s_occ[g] = 32'(o);
  end

  typedef struct {
    logic       mode;
    logic [3:0] x;
    logic [5:0] y;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    logic [9:0] p;
    int         cyc;
  } exp_t;

  exp_t       sq [4][$];
  logic       pv [4];
  logic       pr [4];
  logic [9:0] pm [4];

  function automatic logic [9:0] golden(input logic [10:0] m);
    int xi, yi, p;
    xi = int'(m[9:6]);
    yi = int'(m[5:0]);
    if (m[10]) begin
      if (m[9]) xi -= 16;
      if (m[5]) yi -= 64;
    end
    p = xi * yi;
    return p[9:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step_m(input logic v, input logic [10:0] m, input logic r);
    @(negedge clk);
    in_val = v; in_msg = m; out_rdy = r;
    #4; cyc++;
  endtask

  task automatic step_s(input logic v, input logic [10:0] m, input logic r);
    @(negedge clk);
    s_val = v; s_msg = m; s_rdy = r;
    #4; cyc++;
  endtask

  // Scoreboard: in-flight count equals occupancy, outputs hold under stall, products in order.
  task automatic mon(input int i, input int ns, input logic iv, input logic ir,
                     input logic [10:0] im, input logic ov, input logic ordy,
                     input logic [9:0] om, input logic [31:0] o, input bit exact);
    exp_t e;
    chk($sformatf("occ[%0d]", i), o, sq[i].size());
    if (ns > 0 && pv[i] && !pr[i]) begin
      chk($sformatf("hold_val[%0d]", i), ov, 1);
      chk($sformatf("hold_msg[%0d]", i), om, pm[i]);
    end
    if (iv && ir) sq[i].push_back('{golden(im), cyc});
    if (ov && ordy) begin
      if (sq[i].size() == 0) begin
        chk($sformatf("spurious[%0d]", i), ov, 0);
      end else begin
        e = sq[i].pop_front();
        chk($sformatf("prod[%0d]", i), om, e.p);
        if (exact) chk($sformatf("lat[%0d]", i), cyc - e.cyc, ns);
      end
    end
    pv[i] = ov; pr[i] = ordy; pm[i] = om;
  endtask

  vec_t vt [11];

  initial begin
    logic [10:0] m;
    int          acc_n;

    vt[0]  = '{1'b1, 4'h8, 6'h20, 10'h100};
    vt[1]  = '{1'b0, 4'hF, 6'h3F, 10'h3B1};
    vt[2]  = '{1'b1, 4'hF, 6'h3F, 10'h001};
    vt[3]  = '{1'b0, 4'h0, 6'h00, 10'h000};
    vt[4]  = '{1'b1, 4'h7, 6'h1F, 10'h0D9};
    vt[5]  = '{1'b1, 4'h8, 6'h1F, 10'h308};
    vt[6]  = '{1'b0, 4'h8, 6'h20, 10'h100};
    vt[7]  = '{1'b1, 4'h7, 6'h20, 10'h320};
    vt[8]  = '{1'b0, 4'hF, 6'h01, 10'h00F};
    vt[9]  = '{1'b1, 4'h1, 6'h3F, 10'h3FF};
    vt[10] = '{1'b0, 4'hA, 6'h2B, 10'h1AE};
    for (int i = 0; i < 4; i++) begin pv[i] = 0; pr[i] = 0; pm[i] = '0; end

    rst_n = 0; in_val = 0; in_msg = '0; out_rdy = 1;
    s_rst_n = 0; s_val = 0; s_msg = '0; s_rdy = 1;

    // reset state; data offered during reset is discarded
    step_m(0, '0, 1);
    chk("rst_oval", out_val, 0); chk("rst_occ", occ, 0); chk("rst_irdy", in_rdy, 1);
    step_m(1, 11'h7FF, 1);
    chk("rst_irdy_val", in_rdy, 1);
    step_m(0, '0, 1);
    chk("rst_discard", out_val, 0);
    rst_n = 1;
    repeat (3) begin step_m(0, '0, 1); chk("post_rst_idle", out_val, 0); end

    // vector table: one transaction at a time, product exactly 2 cycles later
    for (int i = 0; i < 11; i++) begin
      step_m(1, {vt[i].mode, vt[i].x, vt[i].y}, 1);
      chk("tbl_irdy", in_rdy, 1); chk("tbl_v0", out_val, 0);
      step_m(0, '0, 1);
      chk("tbl_v1", out_val, 0); chk("tbl_occ", occ, 1);
      step_m(0, '0, 1);
      chk("tbl_val", out_val, 1); chk($sformatf("tbl_prod%0d", i), out_msg, vt[i].exp);
    end

    // back-to-back: 8 on consecutive cycles
    for (int c = 0; c < 11; c++) begin
      m = 11'($urandom);
      step_m(c < 8, m, 1);
      if (c >= 2 && c <= 8) chk("b2b_occ", occ, 2);
      mon(3, 2, in_val, in_rdy, in_msg, out_val, out_rdy, out_msg, 32'(occ), 1);
    end
    chk("b2b_drain", sq[3].size(), 0);

    // backpressure: consumer stalled 5 cycles with 3 inputs offered
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      m = 11'($urandom);
      step_m(acc_n < 3, m, c >= 5);
      if (c >= 2 && c <= 4) chk("bp_irdy", in_rdy, 0);
      if (in_val && in_rdy) acc_n++;
      mon(3, 2, in_val, in_rdy, in_msg, out_val, out_rdy, out_msg, 32'(occ), 0);
    end
    chk("bp_accepted", acc_n, 3);
    chk("bp_drain", sq[3].size(), 0);

    // asynchronous reset mid-cycle with 2 in flight
    step_m(1, 11'h5A5, 1);
    step_m(1, 11'h2C3, 1);
    @(posedge clk); #2;
    chk("pre_rst_oval", out_val, 1); chk("pre_rst_occ", occ, 2);
    rst_n = 0; #1;
    chk("arst_oval", out_val, 0); chk("arst_occ", occ, 0); chk("arst_irdy", in_rdy, 1);
    step_m(0, '0, 1);
    chk("arst_hold", out_val, 0);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin step_m(0, '0, 1); chk("no_stale", out_val, 0); end
    m = 11'h4E7;
    step_m(1, m, 1);
    step_m(0, '0, 1); chk("rel_v1", out_val, 0);
    step_m(0, '0, 1); chk("rel_val", out_val, 1); chk("rel_prod", out_msg, golden(m));

    // depth sweep 0/1/5: first with free-running consumer (exact latency), then random stalls
    step_s(0, '0, 1);
    s_rst_n = 1;
    for (int c = 0; c < 260; c++) begin
      step_s($urandom_range(0, 9) < 7, 11'($urandom), (c < 80) ? 1'b1 : 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++)
        mon(i, NSV[i], s_val, s_irdy[i], s_msg, s_oval[i], s_rdy, s_omsg[i], s_occ[i], c < 80);
    end
    for (int c = 0; c < 10; c++) begin
      step_s(0, '0, 1);
      for (int i = 0; i < 3; i++)
        mon(i, NSV[i], s_val, s_irdy[i], s_msg, s_oval[i], s_rdy, s_omsg[i], s_occ[i], 0);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("sweep_drain[%0d]", i), sq[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
